btb_branch_predictor: RTL and testbench
=======================================

Name: btb_branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters. Used by the next-generation pipelined datapath for fetch-stage PC prediction.
- Fetch looks it up combinationally every cycle. Resolved branches and jumps from the execute/memory resolution point update it.
- Compares each resolved outcome against the prediction carried down the pipe. Raises mispredict plus the corrected PC; the datapath uses this to flush IF/ID and ID/EX.
- Replaces the always-predict-not-taken, resolve-in-MEM scheme.

Parameters:
- ENTRIES, 16: number of BTB entries; power of 2, ≥2; IDX = log2(ENTRIES).
- CTR_BITS, 2: saturating counter width, ≥1.
- ADDR_W, 32: PC/target width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous invalidate of all entries.
- lookup_pc  in  ADDR_W  fetch PC.
- pred_hit  out  1  valid tag match for lookup_pc.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  predicted target.
- upd_valid  in  1  one resolved control-transfer this cycle.
- upd_pc  in  ADDR_W  PC of resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual target.
- upd_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- upd_pred_target  in  ADDR_W  predicted target, carried down the pipe.
- mispredict  out  1  resolved outcome differs from the prediction.
- correct_pc  out  ADDR_W  PC to redirect fetch to.

Behaviour:
- Reset: nRST is asynchronous, active-low; clock is CLK. On reset, all valid bits = 0, all tags/targets = 0, all counters = 0.
- Addressing: index = pc[IDX+1:2]; tag = pc[ADDR_W-1:IDX+2]; pc[1:0] ignored.
- Lookup is purely combinational, zero latency:
  - pred_hit = valid[idx] & tag match.
  - pred_taken = pred_hit & counter[CTR_BITS-1].
  - pred_target = pred_hit ? target[idx] : 0.
- Update is registered and visible to lookups on the cycle after the upd_valid edge. A same-cycle lookup of the entry being updated returns the old contents.
- Update rules when upd_valid = 1 (addressed by upd_pc):
  - Entry hit, taken: counter increments, saturating at all-ones; target overwritten with upd_target.
  - Entry hit, not taken: counter decrements, saturating at 0; target unchanged.
  - Entry miss, taken: allocate. Valid = 1, tag and target written, counter = weakly taken (MSB = 1, rest 0). Any aliasing entry is replaced.
  - Entry miss, not taken: no change.
- mispredict (combinational, gated by upd_valid) = (upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target).
- correct_pc = upd_taken ? upd_target : upd_pc + 4, truncated to ADDR_W bits, wraps at 2^ADDR_W. Both outputs are 0 when upd_valid = 0.
- flush clears all valid bits on the next edge. Counters and targets are left stale but unobservable. flush with upd_valid in the same cycle: flush wins and no allocation occurs. mispredict/correct_pc still compute normally.
- Reset mid-operation: tables clear immediately; combinational outputs follow with pred_hit = 0.
- Maximum one update per cycle; no backpressure. The datapath gates upd_valid with its own stall so that a stalled instruction does not update twice.

Optional Feature:
- Macro BTB_STATS_EN.
- When defined, adds ports:
  - stat_clear  in  1
  - stat_branches  out  32
  - stat_mispredicts  out  32
- Counter behaviour:
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments on each upd_valid & mispredict.
  - Both saturate at 0xFFFFFFFF.
  - Reset or stat_clear sets both to 0; stat_clear wins over a same-cycle increment.
- When undefined: ports and counters are absent; table behaviour is identical.

Test Plan (ENTRIES = 16, CTR_BITS = 2, ADDR_W = 32):
- After reset, lookup_pc = 0x40 → pred_hit = 0, pred_taken = 0, pred_target = 0.
- Update pc 0x40, taken, target 0x100; next cycle lookup 0x40 → hit = 1, taken = 1 (counter 2'b10), target = 0x100. Same-cycle lookup during the update → hit = 0.
- Three not-taken updates on 0x40 → counter 10→01→00→00; pred_taken = 0 after the first; hit stays 1. Four taken updates → 00→01→10→11→11, pred_taken = 1 after the second.
- Alias: 0x40 allocated, then update 0x80 taken, target 0x200 (same index 0) → lookup 0x40 hit = 0; lookup 0x80 target = 0x200, counter 10.
- Mispredict cases:
  - upd_pc 0x40, pred_taken 0, taken 1, target 0x100 → mispredict = 1, correct_pc = 0x100.
  - pred_taken 1, taken 0 → mispredict = 1, correct_pc = 0x44.
  - Both taken, pred_target 0x100 vs target 0x104 → mispredict = 1.
  - upd_pc 0xFFFFFFFC, not taken → correct_pc = 0x0.
- flush with upd_valid (pc 0x40, taken) in the same cycle → next cycle every lookup has hit = 0. With BTB_STATS_EN: stat_branches = 1; stat_clear plus update in the same cycle → 0.

Source files
------------

// File: rtl/btb_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Optional build macro BTB_STATS_EN adds branch / mispredict statistics counters.
module btb_branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] correct_pc
`ifdef BTB_STATS_EN
    ,
    input  logic              stat_clear,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1'b1) << (CTR_BITS - 1);

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        if (c == CTR_MAX) return c;
        else              return c + CTR_BITS'(1'b1);
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        if (c == {CTR_BITS{1'b0}}) return c;
        else                       return c - CTR_BITS'(1'b1);
    endfunction

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [ADDR_W-1:0]   target_q [ENTRIES];
    logic [ADDR_W-1:0]   target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [IDX-1:0]   lk_idx_s, upd_idx_s;
    logic [TAG_W-1:0] lk_tag_s, upd_tag_s;
    logic             upd_hit_s;
    logic             unused_pc_bits_s;

    assign lk_idx_s         = lookup_pc[IDX+1:2];
    assign lk_tag_s         = lookup_pc[ADDR_W-1:IDX+2];
    assign upd_idx_s        = upd_pc[IDX+1:2];
    assign upd_tag_s        = upd_pc[ADDR_W-1:IDX+2];
    assign upd_hit_s        = valid_q[upd_idx_s] & (tag_q[upd_idx_s] == upd_tag_s);
    assign unused_pc_bits_s = ^lookup_pc[1:0];

    // Zero-latency fetch lookup against the registered table
    always_comb begin
        pred_hit   = valid_q[lk_idx_s] & (tag_q[lk_idx_s] == lk_tag_s);
        pred_taken = pred_hit & ctr_q[lk_idx_s][CTR_BITS-1];
        if (pred_hit) pred_target = target_q[lk_idx_s];
        else          pred_target = {ADDR_W{1'b0}};
    end

    // Resolution-side compare against the prediction carried down the pipe
    always_comb begin
        mispredict = 1'b0;
        correct_pc = {ADDR_W{1'b0}};
        if (upd_valid) begin
            mispredict = (upd_taken != upd_pred_taken) |
                         (upd_taken & upd_pred_taken & (upd_target != upd_pred_target));
            if (upd_taken) correct_pc = upd_target;
            else           correct_pc = upd_pc + ADDR_W'(3'd4);
        end else begin
            mispredict = 1'b0;
        end
    end

    // Next table state; flush beats any same-cycle update or allocation
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush) begin
            valid_d = {ENTRIES{1'b0}};
        end else if (upd_valid && upd_hit_s) begin
            if (upd_taken) begin
                ctr_d[upd_idx_s]    = sat_inc(ctr_q[upd_idx_s]);
                target_d[upd_idx_s] = upd_target;
            end else begin
                ctr_d[upd_idx_s]    = sat_dec(ctr_q[upd_idx_s]);
            end
        end else if (upd_valid && upd_taken) begin
            valid_d[upd_idx_s]  = 1'b1;
            tag_d[upd_idx_s]    = upd_tag_s;
            target_d[upd_idx_s] = upd_target;
            ctr_d[upd_idx_s]    = CTR_WEAK;
        end else begin
            valid_d = valid_q;
        end
    end

    // Table storage
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= {ADDR_W{1'b0}};
                ctr_q[i]    <= {CTR_BITS{1'b0}};
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Saturating statistics; clear beats a same-cycle increment
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (stat_clear) begin
            stat_branches_d    = 32'd0;
            stat_mispredicts_d = 32'd0;
        end else begin
            if (upd_valid && (stat_branches_q != 32'hFFFF_FFFF))
                stat_branches_d = stat_branches_q + 32'd1;
            else
                stat_branches_d = stat_branches_q;
            if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            else
                stat_mispredicts_d = stat_mispredicts_q;
        end
    end

    // Statistics registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Scoreboard bench for btb_branch_predictor: directed test-plan cases, then random traffic
// checked against an abstract table model (index/tag by division, counters as integers).
module tb_btb_branch_predictor;

    localparam int ENT  = 16;
    localparam int CB   = 2;
    localparam int CMAX = (1 << CB) - 1;
    localparam int WEAK = 1 << (CB - 1);

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] lookup_pc = 32'd0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = 32'd0;
    logic        mispredict;
    logic [31:0] correct_pc;
`ifdef BTB_STATS_EN
    logic        stat_clear = 1'b0;
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    btb_branch_predictor #(.ENTRIES(ENT), .CTR_BITS(CB), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict), .correct_pc(correct_pc)
`ifdef BTB_STATS_EN
        , .stat_clear(stat_clear), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] cpc;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit          m_valid [ENT];
    logic [31:0] m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_ctr   [ENT];
    longint      m_sb, m_sm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents one response
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pred_hit",    {31'd0, pred_hit},   {31'd0, e.hit});
            chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e.taken});
            chk("pred_target", pred_target,         e.tgt);
            chk("mispredict",  {31'd0, mispredict}, {31'd0, e.mis});
            chk("correct_pc",  correct_pc,          e.cpc);
`ifdef BTB_STATS_EN
            chk("stat_branches",    stat_branches,    e.sb);
            chk("stat_mispredicts", stat_mispredicts, e.sm);
`endif
        end
    end

    task automatic model_clear();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 0;
        end
        m_sb = 0; m_sm = 0;
    endtask

    task automatic step(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utg, input bit upt,
                        input logic [31:0] uptg, input bit fl, input bit sc, input bit rst);
        exp_t e;
        int   li, ui;
        bit   uhit;
        @(posedge CLK);
        #1;
        nRST = !rst; flush = fl; lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
`ifdef BTB_STATS_EN
        stat_clear = sc;
`endif
        if (rst) model_clear();
        li      = int'((lpc / 4) % ENT);
        e.hit   = m_valid[li] && (m_tag[li] == lpc / (4 * ENT));
        e.taken = e.hit && (m_ctr[li] >= WEAK);
        e.tgt   = e.hit ? m_tgt[li] : 32'd0;
        e.mis   = uv && ((ut != upt) || (ut && upt && (utg != uptg)));
        e.cpc   = !uv ? 32'd0 : (ut ? utg : upc + 32'd4);
        e.sb    = m_sb[31:0];
        e.sm    = m_sm[31:0];
        exp_q.push_back(e);
        if (!rst) begin
            ui   = int'((upc / 4) % ENT);
            uhit = m_valid[ui] && (m_tag[ui] == upc / (4 * ENT));
            if (fl) begin
                for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
            end else if (uv && uhit && ut) begin
                m_ctr[ui] = (m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX;
                m_tgt[ui] = utg;
            end else if (uv && uhit) begin
                m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
            end else if (uv && ut) begin
                m_valid[ui] = 1'b1; m_tag[ui] = upc / (4 * ENT); m_tgt[ui] = utg; m_ctr[ui] = WEAK;
            end
            if (sc) begin
                m_sb = 0; m_sm = 0;
            end else begin
                if (uv && m_sb < 64'hFFFF_FFFF) m_sb++;
                if (e.mis && m_sm < 64'hFFFF_FFFF) m_sm++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, tg;
        model_clear();
        // reset state, then allocate with a same-cycle lookup that must still miss
        step(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        step(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 0, 0);
        step(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        // counter walks down, then back up to saturation
        step(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(32'h40, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        step(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h104, 0, 0, 0);
        step(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        // alias replacement at index 0
        step(32'h40, 1, 32'h80, 1, 32'h200, 0, 32'h0, 0, 0, 0);
        step(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        step(32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        // fall-through wraps past the top of the address space
        step(32'h80, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        // flush beats a same-cycle allocation
        step(32'h80, 1, 32'h40, 1, 32'h100, 0, 32'h0, 1, 0, 0);
        step(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        step(32'h80, 1, 32'h44, 1, 32'h300, 1, 32'h300, 0, 1, 0);
        step(32'h44, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        // randomized traffic over a small PC pool so hits and aliases are frequent
        for (int n = 0; n < 600; n++) begin
            bit r_uv, r_ut, r_pt, r_fl, r_sc, r_rst;
            logic [31:0] lpc, ptg;
            lpc   = ($urandom_range(0, 3) * 64) + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
            pc    = ($urandom_range(0, 3) * 64) + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
            if ($urandom_range(0, 40) == 0) pc = 32'hFFFF_FFFC;
            tg    = $urandom();
            r_uv  = ($urandom_range(0, 3) != 0);
            r_ut  = $urandom_range(0, 1) != 0;
            r_pt  = $urandom_range(0, 1) != 0;
            ptg   = ($urandom_range(0, 1) != 0) ? tg : $urandom();
            r_fl  = ($urandom_range(0, 31) == 0);
            r_sc  = ($urandom_range(0, 31) == 0);
            r_rst = ($urandom_range(0, 199) == 0);
            step(lpc, r_uv, pc, r_ut, tg, r_pt, ptg, r_fl, r_sc, r_rst);
        end
        step(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
